// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle 32-bit DIV/DIVU controller for the EX stage.
// Restoring divider, one quotient bit per cycle, with optional sign
// correction and a divide-by-zero shortcut.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start, signed_div  - divide request and signedness (sampled in IDLE)
//   opa, opb           - dividend and divisor (sampled in IDLE)
//   annul              - pipeline flush, cancels any divide in progress
//   stall_div          - combinational hold for IF/ID/EX
//   ready              - one-cycle pulse, result valid
//   result             - {remainder, quotient}
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        annul,
  output logic        stall_div,
  output logic        ready,
  output logic [63:0] result
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 5;
  localparam int unsigned LAST = 31;

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    rem_q, rem_d;      // partial remainder (top bit of the 33-bit trial is transient)
  logic [W-1:0]    quo_q, quo_d;      // dividend bits shift out as quotient bits shift in
  logic [W-1:0]    dvs_q, dvs_d;      // divisor magnitude
  logic            neg_a_q, neg_a_d;  // dividend negative (signed only)
  logic            neg_b_q, neg_b_d;  // divisor negative (signed only)
  logic            ready_q, ready_d;
  logic [2*W-1:0]  result_q, result_d;

  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      shifted, diff;
  logic [W-1:0]    q_step, r_step, q_fix, r_fix;

  // Operand magnitudes for the request being sampled.
  always_comb begin
    a_mag = (signed_div && opa[W-1]) ? W'(~opa + 32'd1) : opa;
    b_mag = (signed_div && opb[W-1]) ? W'(~opb + 32'd1) : opb;
  end

  // One restoring step plus final sign correction of that step's outcome.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[W]) begin
      r_step = diff[W-1:0];
      q_step = {quo_q[W-2:0], 1'b1};
    end else begin
      r_step = shifted[W-1:0];
      q_step = {quo_q[W-2:0], 1'b0};
    end
    q_fix = (neg_a_q ^ neg_b_q) ? W'(~q_step + 32'd1) : q_step;
    r_fix = neg_a_q ? W'(~r_step + 32'd1) : r_step;
  end

  // Next-state, datapath and stall logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    ready_d   = 1'b0;
    result_d  = result_q;
    stall_div = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          stall_div = 1'b1;
          neg_a_d   = signed_div & opa[W-1];
          neg_b_d   = signed_div & opb[W-1];
          cnt_d     = '0;
          rem_d     = '0;
          if (opb == 32'd0) begin
            // Raw dividend kept so it can be returned unmodified as remainder.
            state_d = DIVZERO;
            quo_d   = opa;
            dvs_d   = '0;
          end else begin
            state_d = BUSY;
            quo_d   = a_mag;
            dvs_d   = b_mag;
          end
        end
      end
      DIVZERO: begin
        // Fixed divide-by-zero answer, no sign correction applied.
        stall_div = 1'b1;
        state_d   = DONE;
        ready_d   = 1'b1;
        result_d  = {quo_q, 32'hFFFF_FFFF};
      end
      BUSY: begin
        stall_div = 1'b1;
        rem_d     = r_step;
        quo_d     = q_step;
        cnt_d     = CW'(cnt_q + 5'd1);
        if (cnt_q == CW'(LAST)) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = {r_fix, q_fix};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush wins over every other transition and suppresses the result.
    if (annul) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed scoreboard bench for div_ctrl.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        annul;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .annul      (annul),
    .stall_div  (stall_div),
    .ready      (ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Issue a divide at the current cycle (called just after a rising edge).
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start      = 1'b1;
    signed_div = sgn;
    opa        = a;
    opb        = b;
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat);
    exp_t e;
    @(posedge clk); #1;
    issue(sgn, a, b);
    e.res = exp;
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(60);
  endtask

  initial begin
    int c0;
    exp_t e;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0; annul = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_stall_idle", 64'(stall_div), 64'd0);
    start = 1'b1;
    @(negedge clk);
    check("rst_stall_start", 64'(stall_div), 64'd1);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // DIVU 100/7 with latency and stall window, start dropped during BUSY.
    issue(1'b0, 32'd100, 32'd7);
    c0 = cyc;
    e.res = 64'h00000002_0000000E;
    e.cyc = c0 + 33;
    sb.push_back(e);
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      check($sformatf("stall_k%0d", k), 64'(stall_div), (k <= 32) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
      if (k == 0) start = 1'b0;
    end
    wait_drain(10);

    // Signed cases.
    run_div(1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run_div(1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_div(1'b0, 32'hFFFFFFFF, 32'h10,       64'h0000000F_0FFFFFFF, 33);

    // Divide by zero.
    run_div(1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 2);

    // Annul in cycle 10 of a divide: back to IDLE, result kept.
    @(posedge clk); #1;
    issue(1'b0, 32'd100, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    check("annul_stall", 64'(stall_div), 64'd0);
    check("annul_result", result, 64'h00000005_FFFFFFFF);
    repeat (40) @(posedge clk);
    #1;
    check("annul_result_hold", result, 64'h00000005_FFFFFFFF);
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // annul together with start in IDLE.
    @(posedge clk); #1;
    issue(1'b0, 32'd50, 32'd5);
    annul = 1'b1;
    @(negedge clk);
    check("annul_start_stall", 64'(stall_div), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("annul_start_idle", 64'(stall_div), 64'd0);

    // start presented in DONE must not begin a new divide.
    @(posedge clk); #1;
    issue(1'b0, 32'd100, 32'd7);
    e.res = 64'h00000002_0000000E;
    e.cyc = cyc + 33;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    issue(1'b0, 32'd8, 32'd2);
    @(negedge clk);
    check("done_stall", 64'(stall_div), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("after_done_stall", 64'(stall_div), 64'd0);
    wait_drain(10);
    repeat (40) @(posedge clk);
    #1;

    // Reset in cycle 20 of a divide.
    issue(1'b0, 32'd100, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_stall", 64'(stall_div), 64'd0);
    check("rst_mid_result", result, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port start, input, 1: a DIV/DIVU instruction is in EX and requests a divide.
REQ-005 Port signed_div, input, 1: 1 = DIV (signed), 0 = DIVU (unsigned); sampled together with start.
REQ-006 Port opa, input, 32: dividend (rs); sampled together with start.
REQ-007 Port opb, input, 32: divisor (rt); sampled together with start.
REQ-008 Port annul, input, 1: pipeline flush (exception or eret); cancels any divide in progress.
REQ-009 Port stall_div, output, 1: holds IF/ID/EX while the divide is running.
REQ-010 Port ready, output, 1: one-cycle pulse marking result valid; the consumer writes hi/lo in that cycle.
REQ-011 Port result, output, 64: {remainder, quotient}; [63:32] goes to hi and [31:0] goes to lo.

Function
REQ-012 The block SHALL implement a state machine with four states: IDLE, DIVZERO, BUSY, DONE.
REQ-013 IDLE with start=1, annul=0 and opb==0 SHALL move to DIVZERO.
REQ-014 IDLE with start=1, annul=0 and opb!=0 SHALL move to BUSY. On that edge it SHALL latch:
- |opa| and |opb| (two's-complement magnitude when signed_div=1, raw values otherwise);
- the sign of opa and the sign of opb, when signed;
- step count = 0.
REQ-015 IDLE with start=0, or with annul=1, SHALL stay in IDLE.
REQ-016 BUSY SHALL perform one restoring-division step per cycle:
- 33-bit partial remainder, shifted left with the next dividend MSB;
- trial-subtract the divisor magnitude;
- if the difference is non-negative, keep it and shift a 1 into the quotient; otherwise shift a 0.
REQ-017 BUSY SHALL last exactly 32 cycles (count 0..31); the edge that ends step 31 SHALL move to DONE.
REQ-018 DIVZERO SHALL last one cycle, then move to DONE with quotient = 32'hFFFFFFFF and remainder = opa as sampled.
REQ-019 On entry to DONE, sign correction SHALL apply when signed_div=1:
- quotient is negated if the operand signs differ;
- remainder is negated if opa was negative;
- all arithmetic is mod 2^32, so 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
REQ-020 DONE SHALL assert ready=1 for exactly one cycle and move to IDLE unconditionally; start in DONE SHALL NOT begin a new divide.
REQ-021 stall_div SHALL be a combinational OR of:
- (state==IDLE and start and !annul);
- state==BUSY;
- state==DIVZERO.
It SHALL be 0 in DONE so the pipeline advances.
REQ-022 Latency: with start in cycle 0 (opb!=0), ready=1 in cycle 33 and stall_div=1 in cycles 0..32. With opb==0, ready=1 in cycle 2.
REQ-023 result SHALL be registered and hold its value from DONE until the next DONE; it SHALL change at no other time.
REQ-024 annul=1 in BUSY, DIVZERO or DONE SHALL force IDLE on the next edge:
- no ready pulse in the following cycle;
- result unchanged from its previous value;
- annul has priority over all other transitions.
REQ-025 annul and start together in IDLE SHALL leave the block in IDLE with stall_div=0.
REQ-026 start deasserting during BUSY SHALL NOT abort the divide; only annul or rst abort.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, step count 0, result 64'h0 and all internal registers 0, from any state.
REQ-028 During and after reset, ready=0; stall_div=0 unless start=1, annul=0 in IDLE (REQ-021 applies combinationally).
REQ-029 rst SHALL take priority over annul and start.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- DIVU, opa=100, opb=7, start in cycle 0 -> ready in cycle 33; result hi=2, lo=14; stall_div high in cycles 0..32 only.
- DIV, opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV, opa=0x80000000, opb=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, no hang.
- DIVU, opa=5, opb=0 -> ready in cycle 2; lo=0xFFFFFFFF, hi=5.
- DIVU 100/7 with annul=1 in cycle 10 -> IDLE in cycle 11; no ready; result keeps its prior value. A fresh start 9/3 then gives lo=3, hi=0.
- rst=1 in cycle 20 of a divide -> cycle 21: IDLE, result=0, ready=0, stall_div=0 with start=0.
